// File: rtl/wb_pkg.sv
// Shared constants and types for the RV32I writeback stage.
package wb_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

  // Everything about an outstanding load that is needed once its data returns.
  typedef struct packed {
    logic       rd_wen;
    logic [4:0] rd_addr;
    logic [2:0] funct3;
    logic [1:0] offset;
  } load_req_t;

endpackage

// File: rtl/wb_if.sv
// MEM->WB handshake, data memory response and register file write port.
interface wb_if;
  import wb_pkg::*;

  logic            mem_valid;
  logic            wb_ready;
  logic            mem_rd_wen;
  logic [4:0]      mem_rd_addr;
  logic            mem_is_load;
  logic [2:0]      mem_funct3;
  logic [XLEN-1:0] mem_result;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;
  logic            wr_en;
  logic [4:0]      wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            load_pending;
  logic [4:0]      load_rd;
  logic            misalign_err;

  modport slave (
    input  mem_valid, mem_rd_wen, mem_rd_addr, mem_is_load, mem_funct3, mem_result,
    input  dmem_rvalid, dmem_rdata,
    output wb_ready, wr_en, wr_addr, wr_data, load_pending, load_rd, misalign_err
  );

  modport master (
    output mem_valid, mem_rd_wen, mem_rd_addr, mem_is_load, mem_funct3, mem_result,
    output dmem_rvalid, dmem_rdata,
    input  wb_ready, wr_en, wr_addr, wr_data, load_pending, load_rd, misalign_err
  );

endinterface

// File: rtl/wb_load_align.sv
// Combinational load data extraction: shift by byte offset, then sign/zero extend.
module load_align
  import wb_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] value,
  output logic            misaligned
);

  logic [XLEN-1:0] byte_sh;
  logic [XLEN-1:0] half_sh;

  assign byte_sh = word >> {offset, 3'b000};
  assign half_sh = word >> {offset[1], 4'b0000};

  // Unused funct3 encodings fall through to the word path.
  always_comb begin
    value      = byte_sh;
    misaligned = (offset != 2'b00);
    case (funct3)
      F3_LB: begin
        value      = {{24{byte_sh[7]}}, byte_sh[7:0]};
        misaligned = 1'b0;
      end
      F3_LBU: begin
        value      = {24'h0, byte_sh[7:0]};
        misaligned = 1'b0;
      end
      F3_LH: begin
        value      = {{16{half_sh[15]}}, half_sh[15:0]};
        misaligned = offset[0];
      end
      F3_LHU: begin
        value      = {16'h0, half_sh[15:0]};
        misaligned = offset[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage: retires ALU results and variable-latency loads.
// Optional WB_MISALIGN_TRAP_EN drops misaligned loads and pulses misalign_err.
module wb_stage
  import wb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  wb_if.slave  bus
);

  wb_state_e       state_q, state_d;
  load_req_t       ld_q, ld_d;
  logic            wr_en_q, wr_en_d;
  logic [4:0]      wr_addr_q, wr_addr_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;
  logic            pend_q, pend_d;
  logic [4:0]      load_rd_q, load_rd_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] ld_value;
  logic            ld_misaligned;
  logic            drop_load;

  load_align u_align (
    .word       (bus.dmem_rdata),
    .offset     (ld_q.offset),
    .funct3     (ld_q.funct3),
    .value      (ld_value),
    .misaligned (ld_misaligned)
  );

`ifdef WB_MISALIGN_TRAP_EN
  assign drop_load = ld_misaligned;
`else
  logic unused_misaligned;
  assign unused_misaligned = ld_misaligned;
  assign drop_load         = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ld_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      pend_q    <= 1'b0;
      load_rd_q <= '0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_q      <= ld_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      pend_q    <= pend_d;
      load_rd_q <= load_rd_d;
      mis_q     <= mis_d;
    end
  end

  // wr_addr/wr_data hold between writes; only wr_en qualifies them.
  always_comb begin
    state_d   = state_q;
    ld_d      = ld_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    mis_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_valid) begin
          if (bus.mem_is_load) begin
            ld_d.rd_wen  = bus.mem_rd_wen;
            ld_d.rd_addr = bus.mem_rd_addr;
            ld_d.funct3  = bus.mem_funct3;
            ld_d.offset  = bus.mem_result[1:0];
            state_d      = WAIT_LOAD;
          end else begin
            wr_en_d   = bus.mem_rd_wen && (bus.mem_rd_addr != 5'd0);
            wr_addr_d = bus.mem_rd_addr;
            wr_data_d = bus.mem_result;
          end
        end
      end
      WAIT_LOAD: begin
        if (bus.dmem_rvalid) begin
          state_d   = IDLE;
          wr_en_d   = ld_q.rd_wen && (ld_q.rd_addr != 5'd0) && !drop_load;
          wr_addr_d = ld_q.rd_addr;
          wr_data_d = ld_value;
          mis_d     = drop_load;
        end
      end
      default: state_d = IDLE;
    endcase
    pend_d    = (state_d == WAIT_LOAD);
    load_rd_d = (state_d == WAIT_LOAD) ? ld_d.rd_addr : 5'd0;
  end

  assign bus.wb_ready     = (state_q == IDLE);
  assign bus.wr_en        = wr_en_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.load_pending = pend_q;
  assign bus.load_rd      = load_rd_q;
  assign bus.misalign_err = mis_q;

endmodule
